medfilt_sched: RTL and testbench

- Time-multiplexed scheduler and controller that shares one 3-tap median datapath between NCH independent sample streams.
- Arbitrates requesters round-robin and keeps a 2-sample history per channel.
- Sequences each channel's warm-up, computes the signed median of the current and two previous samples, and presents results on a valid/ready output.
- Sits between the input sample sources and the output pad register stage of the filter chip.

---
 rtl/medfilt_pkg.sv | 18 +
 rtl/median3.sv | 41 ++++
 rtl/medfilt_sched.sv | 116 +++++++++++
 tb/tb_medfilt_sched.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/medfilt_pkg.sv
// Shared definitions for the median-filter scheduler.
//   DEF_DATA_W / DEF_NCH : default sample width and channel count
//   fill_t               : per-channel history fill state
//   sample_t             : signed sample at the default width
package medfilt_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_NCH    = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/median3.sv
// Combinational signed median of three samples.
//   a, b, c : signed input samples
//   med     : median of the three (ties resolve to the repeated value)
module median3
    import medfilt_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    output logic signed [DATA_W-1:0] med
);

    // One extra bit keeps the difference of two signed values from overflowing,
    // so the top bit is an exact "less than" flag.
    logic [DATA_W:0] d_ab;
    logic [DATA_W:0] d_bc;
    logic [DATA_W:0] d_ac;
    logic            lt_ab;
    logic            lt_bc;
    logic            lt_ac;

    assign d_ab  = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    assign d_bc  = {b[DATA_W-1], b} - {c[DATA_W-1], c};
    assign d_ac  = {a[DATA_W-1], a} - {c[DATA_W-1], c};
    assign lt_ab = d_ab[DATA_W];
    assign lt_bc = d_bc[DATA_W];
    assign lt_ac = d_ac[DATA_W];

    always_comb begin
        if (lt_ab == lt_bc) begin
            med = b;
        end else if (lt_ab != lt_ac) begin
            med = a;
        end else begin
            med = c;
        end
    end

endmodule

// File: rtl/medfilt_sched.sv
// Shares one 3-tap median datapath between NCH sample streams.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-channel sample valid
//   req_data   : per-channel samples, channel i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot round-robin grant (combinational, 0 in reset)
//   clr        : per-channel history clear, wins over a same-cycle transfer
//   out_valid / out_ready / out_data / out_ch : registered result handshake
module medfilt_sched
    import medfilt_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NCH    = DEF_NCH,
    parameter int unsigned CH_W   = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req_valid,
    input  logic [NCH*DATA_W-1:0] req_data,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH-1:0]        clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [CH_W-1:0]       out_ch
);

    fill_t                    fill_q [NCH];
    logic signed [DATA_W-1:0] h1_q   [NCH];
    logic signed [DATA_W-1:0] h2_q   [NCH];
    logic [CH_W-1:0]          rr_ptr_q;
    logic                     out_valid_q;
    logic [DATA_W-1:0]        out_data_q;
    logic [CH_W-1:0]          out_ch_q;

    logic                     can_acc;
    logic                     grant_valid;
    logic [CH_W-1:0]          grant_idx;
    logic signed [DATA_W-1:0] grant_x;
    logic signed [DATA_W-1:0] grant_med;

    assign can_acc = !out_valid_q || out_ready;

    // Scan from the highest offset down so the closest eligible channel to
    // rr_ptr is the last (and winning) assignment.
    always_comb begin : arb_search
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % int'(NCH);
            if (can_acc && req_valid[CH_W'(idx)] && !clr[CH_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    assign req_ready = (rst_n && grant_valid) ? (NCH'(1) << grant_idx) : '0;
    assign grant_x   = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    median3 #(
        .DATA_W (DATA_W)
    ) u_median3 (
        .a   (grant_x),
        .b   (h1_q[grant_idx]),
        .c   (h2_q[grant_idx]),
        .med (grant_med)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                fill_q[i] <= EMPTY;
                h1_q[i]   <= '0;
                h2_q[i]   <= '0;
            end
        end else begin
            if (grant_valid) begin
                rr_ptr_q        <= (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
                h1_q[grant_idx] <= grant_x;
                if (fill_q[grant_idx] != EMPTY) begin
                    h2_q[grant_idx] <= h1_q[grant_idx];
                end
                fill_q[grant_idx] <= (fill_q[grant_idx] == EMPTY) ? ONE : FULL;
            end

            if (grant_valid && fill_q[grant_idx] == FULL) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_med;
                out_ch_q    <= grant_idx;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A cleared channel is never granted, so this cannot collide with
            // the update above.
            for (int i = 0; i < int'(NCH); i++) begin
                if (clr[i]) begin
                    fill_q[i] <= EMPTY;
                    h1_q[i]   <= '0;
                    h2_q[i]   <= '0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_medfilt_sched.sv
module tb_medfilt_sched;

    localparam int DATA_W = 8;
    localparam int NCH    = 4;
    localparam int CH_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NCH-1:0]        req_valid;
    logic [NCH*DATA_W-1:0] req_data;
    logic [NCH-1:0]        req_ready;
    logic [NCH-1:0]        clr;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [CH_W-1:0]       out_ch;

    int checks = 0;
    int errors = 0;

    // Reference model: sample count and last two samples per channel.
    int m_cnt [NCH];
    int m_p1  [NCH];
    int m_p2  [NCH];
    int m_ptr;
    int m_ov;
    int m_od;
    int m_och;

    always #5 clk = ~clk;

    medfilt_sched #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .CH_W   (CH_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    function automatic int med3(input int a, input int b, input int c);
        int t;
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
        return b;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if ((m_ov == 0 || out_ready) && req_valid[c] && !clr[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
        end
        m_ptr = 0; m_ov = 0; m_od = 0; m_och = 0;
    endtask

    task automatic model_edge(input int g);
        bit loaded;
        int x;
        loaded = 0;
        for (int i = 0; i < NCH; i++) if (clr[i]) m_cnt[i] = 0;
        if (g >= 0) begin
            x = int'($signed(req_data[g*DATA_W +: DATA_W]));
            if (m_cnt[g] >= 2) begin
                m_od   = med3(x, m_p1[g], m_p2[g]);
                m_och  = g;
                m_ov   = 1;
                loaded = 1;
            end
            m_p2[g]  = m_p1[g];
            m_p1[g]  = x;
            m_cnt[g] = (m_cnt[g] >= 2) ? 2 : m_cnt[g] + 1;
            m_ptr    = (g + 1) % NCH;
        end
        if (!loaded && out_ready) m_ov = 0;
    endtask

    task automatic set_sample(input int ch, input int val);
        req_data[ch*DATA_W +: DATA_W] = DATA_W'(val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        clr       = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = 32'h01020304;
        clr       = '0;
        out_ready = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %0h expected 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++; $display("FAIL reset_out_data got %0h expected 0", out_data);
        end
        checks++;
        if (out_ch !== 2'd0) begin
            errors++; $display("FAIL reset_out_ch got %0h expected 0", out_ch);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got %0h expected 0", req_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held got valid %0h ready %0h expected 0 0", out_valid, req_ready);
        end
        do_reset();
    endtask

    task automatic test_warmup();
        int smp[4] = '{10, -5, 3, 100};
        bit ev[4]  = '{0, 0, 1, 1};
        int ed[4]  = '{0, 0, 3, 3};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0001;
            set_sample(0, smp[k]);
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++; $display("FAIL warmup_ready[%0d] got %0h expected 1", k, req_ready);
            end
            step();
            checks++;
            if (out_valid !== ev[k]) begin
                errors++;
                $display("FAIL warmup_valid[%0d] got %0h expected %0h", k, out_valid, ev[k]);
            end
            if (ev[k]) begin
                checks++;
                if (out_data !== DATA_W'(ed[k]) || out_ch !== 2'd0) begin
                    errors++;
                    $display("FAIL warmup_data[%0d] got %0h/%0h expected %0h/0",
                             k, out_data, out_ch, DATA_W'(ed[k]));
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int seq1[6] = '{0, 1, 2, 3, 0, 1};
        int seq2[4] = '{3, 0, 1, 3};
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            req_data = $urandom;
            #1;
            checks++;
            if (req_ready !== NCH'(1 << seq1[k])) begin
                errors++;
                $display("FAIL rr_all[%0d] got %0h expected %0h", k, req_ready,
                         NCH'(1 << seq1[k]));
            end
            step();
        end
        req_valid = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            req_data = $urandom;
            #1;
            checks++;
            if (req_ready !== NCH'(1 << seq2[k])) begin
                errors++;
                $display("FAIL rr_skip[%0d] got %0h expected %0h", k, req_ready,
                         NCH'(1 << seq2[k]));
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        set_sample(1, 5);  step();
        set_sample(1, 7);  step();
        out_ready = 1'b0;
        set_sample(1, 6);  step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd6 || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL bp_load got %0h/%0h/%0h expected 1/06/1", out_valid, out_data, out_ch);
        end
        req_valid = 4'b0011;
        set_sample(1, 50);
        set_sample(0, 9);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d] got %0h expected 0", k, req_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd6 || out_ch !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got %0h/%0h/%0h expected 1/06/1",
                         k, out_valid, out_data, out_ch);
            end
        end
        req_valid = 4'b0010;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready got %0h expected 2", req_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd7 || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL bp_release_out got %0h/%0h/%0h expected 1/07/1",
                     out_valid, out_data, out_ch);
        end
        req_valid = '0;
    endtask

    task automatic test_extremes();
        int smp[6] = '{-128, 127, 0, -128, -128, 127};
        bit ev[6]  = '{0, 0, 1, 1, 1, 1};
        int ed[6]  = '{0, 0, 0, 0, -128, -128};
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            set_sample(3, smp[k]);
            step();
            checks++;
            if (out_valid !== ev[k]) begin
                errors++;
                $display("FAIL ext_valid[%0d] got %0h expected %0h", k, out_valid, ev[k]);
            end
            if (ev[k]) begin
                checks++;
                if (out_data !== DATA_W'(ed[k]) || out_ch !== 2'd3) begin
                    errors++;
                    $display("FAIL ext_data[%0d] got %0h/%0h expected %0h/3",
                             k, out_data, out_ch, DATA_W'(ed[k]));
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_clr();
        int smp[3] = '{4, 5, 6};
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0100;
        set_sample(2, 1); step();
        set_sample(2, 2); step();
        set_sample(2, 3); step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd2) begin
            errors++; $display("FAIL clr_fill got %0h/%0h expected 1/02", out_valid, out_data);
        end
        // Collision: ch2 requests and clears together, ch1 also requests.
        req_valid = 4'b0110;
        clr       = 4'b0100;
        set_sample(2, 9);
        set_sample(1, 4);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL clr_collide_ready got %0h expected 2", req_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL clr_collide_out got %0h expected 0", out_valid);
        end
        clr       = '0;
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_sample(2, smp[k]);
            if (k == 2) out_ready = 1'b0;
            step();
            checks++;
            if (out_valid !== (k == 2)) begin
                errors++;
                $display("FAIL clr_refill_valid[%0d] got %0h expected %0h", k, out_valid, k == 2);
            end
        end
        checks++;
        if (out_data !== 8'd5 || out_ch !== 2'd2) begin
            errors++; $display("FAIL clr_refill_data got %0h/%0h expected 05/2", out_data, out_ch);
        end
        // Clearing must not disturb a result already waiting downstream.
        req_valid = '0;
        clr       = 4'b0100;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd5 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL clr_keep_out got %0h/%0h/%0h expected 1/05/2",
                     out_valid, out_data, out_ch);
        end
        clr       = '0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        int chs[5]  = '{0, 1, 0, 1, 0};
        int vals[5] = '{7, 8, 9, 10, 11};
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0001;
        set_sample(0, 1); step();
        set_sample(0, 2); step();
        out_ready = 1'b0;
        set_sample(0, 3); step();
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL arst_pre got %0h expected 1", out_valid);
        end
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL arst_drop got %0h/%0h/%0h expected 0/00/0",
                     out_valid, out_data, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = NCH'(1 << chs[k]);
            set_sample(chs[k], vals[k]);
            step();
            checks++;
            if (out_valid !== (k == 4)) begin
                errors++;
                $display("FAIL arst_warm[%0d] got %0h expected %0h", k, out_valid, k == 4);
            end
        end
        checks++;
        if (out_data !== 8'd9 || out_ch !== 2'd0) begin
            errors++; $display("FAIL arst_data got %0h/%0h expected 09/0", out_data, out_ch);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int g;
        logic [NCH-1:0] exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = NCH'($urandom);
            clr       = ($urandom_range(0, 7) == 0) ? NCH'($urandom & $urandom) : '0;
            out_ready = ($urandom_range(0, 3) != 0);
            req_data  = $urandom;
            #1;
            g       = model_grant();
            exp_rdy = (g >= 0) ? NCH'(1 << g) : '0;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready[%0d] got %0h expected %0h", cyc, req_ready, exp_rdy);
            end
            @(posedge clk);
            model_edge(g);
            #1;
            checks++;
            if (out_valid !== m_ov[0]) begin
                errors++;
                $display("FAIL rand_valid[%0d] got %0h expected %0h", cyc, out_valid, m_ov[0]);
            end
            if (m_ov != 0) begin
                checks++;
                if (out_data !== DATA_W'(m_od) || out_ch !== CH_W'(m_och)) begin
                    errors++;
                    $display("FAIL rand_out[%0d] got %0h/%0h expected %0h/%0h", cyc,
                             out_data, out_ch, DATA_W'(m_od), CH_W'(m_och));
                end
            end
        end
        req_valid = '0;
        clr       = '0;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_clr();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
